multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/op_class.sv | 21 ++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrlState_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // One-hot instruction class; exactly one field is set for any opcode.
    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic branch;
        logic illegal;
    } opClass_t;

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier: 7-bit opcode to one-hot instruction class.
module op_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opClass_t   cls
);

    // Anything outside the four supported opcodes is flagged illegal.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_LOAD:   cls.load    = 1'b1;
            OP_STORE:  cls.store   = 1'b1;
            OP_RTYPE:  cls.rtype   = 1'b1;
            OP_BRANCH: cls.branch  = 1'b1;
            default:   cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback
// sequencing, sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                memReady,
    input  logic                zero,
    output logic                memReq,
    output logic                iorD,
    output logic                memWrite,
    output logic                irWrite,
    output logic                pcWrite,
    output logic                pcSrc,
    output logic                regWrite,
    output logic                aluSrc,
    output logic [3:0]          aluOp,
    output logic                memToReg,
    output logic                branch,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] instret
);

    ctrlState_t curState;
    ctrlState_t nextState;
    opClass_t   cls;
    logic       retire;
    logic       unusedInstrBits;

    // Only the opcode and the add/sub selector bit matter to control.
    assign unusedInstrBits = ^{instr[31], instr[29:7]};

    op_class uOpClass (
        .opcode (instr[6:0]),
        .cls    (cls)
    );

    assign state = curState;

    // State, retire counter and sticky trap flag; reset returns to a clean fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= FETCH;
            instret  <= '0;
            illegal  <= 1'b0;
        end else begin
            curState <= nextState;
            if (retire) begin
                instret <= instret + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end
            if (nextState == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; reset overrides every strobe so an
    // in-flight memory access is dropped immediately.
    always_comb begin
        nextState = FETCH;
        memReq    = 1'b0;
        iorD      = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 1'b0;
        regWrite  = 1'b0;
        aluSrc    = 1'b0;
        aluOp     = ALU_ADD;
        memToReg  = 1'b0;
        branch    = 1'b0;
        retire    = 1'b0;

        case (curState)
            FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end else begin
                    nextState = FETCH;
                end
            end
            DECODE: begin
                nextState = cls.illegal ? TRAP : EXEC;
            end
            EXEC: begin
                if (cls.load || cls.store) begin
                    aluOp     = ALU_ADD;
                    nextState = MEM;
                end else if (cls.rtype) begin
                    aluSrc    = 1'b1;
                    aluOp     = instr[30] ? ALU_SUB : ALU_ADD;
                    nextState = WB;
                end else if (cls.branch) begin
                    aluSrc    = 1'b1;
                    aluOp     = ALU_SUB;
                    branch    = 1'b1;
                    pcWrite   = zero;
                    pcSrc     = zero;
                    retire    = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextState = TRAP;
                end
            end
            MEM: begin
                memReq   = 1'b1;
                iorD     = 1'b1;
                memWrite = cls.store;
                if (memReady) begin
                    retire    = cls.store;
                    nextState = cls.store ? FETCH : WB;
                end else begin
                    nextState = MEM;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                memToReg  = cls.load;
                retire    = 1'b1;
                nextState = FETCH;
            end
            TRAP: begin
                nextState = TRAP;
            end
            default: begin
                nextState = FETCH;
            end
        endcase

        if (reset) begin
            memReq   = 1'b0;
            iorD     = 1'b0;
            memWrite = 1'b0;
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            pcSrc    = 1'b0;
            regWrite = 1'b0;
            aluSrc   = 1'b0;
            aluOp    = ALU_ADD;
            memToReg = 1'b0;
            branch   = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected cycle-by-cycle timeline, then replayed against the DUT.
module tb_multicycle_ctrl;

    localparam int RW = 4;

    localparam int K_LOAD    = 0;
    localparam int K_STORE   = 1;
    localparam int K_RTYPE   = 2;
    localparam int K_BRANCH  = 3;
    localparam int K_ILLEGAL = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   instr;
    logic          memReady;
    logic          zero;
    logic          memReq;
    logic          iorD;
    logic          memWrite;
    logic          irWrite;
    logic          pcWrite;
    logic          pcSrc;
    logic          regWrite;
    logic          aluSrc;
    logic [3:0]    aluOp;
    logic          memToReg;
    logic          branch;
    logic [2:0]    state;
    logic          illegal;
    logic [RW-1:0] instret;
    logic [13:0]   obsOuts;

    multicycle_ctrl #(.RETIRE_W(RW)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .memReady (memReady),
        .zero     (zero),
        .memReq   (memReq),
        .iorD     (iorD),
        .memWrite (memWrite),
        .irWrite  (irWrite),
        .pcWrite  (pcWrite),
        .pcSrc    (pcSrc),
        .regWrite (regWrite),
        .aluSrc   (aluSrc),
        .aluOp    (aluOp),
        .memToReg (memToReg),
        .branch   (branch),
        .state    (state),
        .illegal  (illegal),
        .instret  (instret)
    );

    assign obsOuts = {memReq, iorD, memWrite, irWrite, pcWrite, pcSrc,
                      regWrite, aluSrc, aluOp, memToReg, branch};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        mr;
        logic        z;
        logic [31:0] ins;
        logic [13:0] outs;
        logic        retire;
        logic        trapAfter;
    } cycle_t;

    cycle_t      plan[$];
    int          checks = 0;
    int          errors = 0;
    int          expInstret = 0;
    logic        expIllegal = 1'b0;
    logic [31:0] lastInstr = 32'h0;

    // Pack expected strobes in the same order as obsOuts.
    function automatic logic [13:0] pk(input logic mReq, input logic mAddr,
                                       input logic mWr, input logic irW,
                                       input logic pcW, input logic pcS,
                                       input logic rgW, input logic aSrc,
                                       input logic [3:0] aOp, input logic m2r,
                                       input logic br);
        return {mReq, mAddr, mWr, irW, pcW, pcS, rgW, aSrc, aOp, m2r, br};
    endfunction

    function automatic logic [31:0] mkWord(input int kind, input logic bit30);
        logic [31:0] w;
        w = $urandom;
        case (kind)
            K_LOAD:   w[6:0] = 7'b0000011;
            K_STORE:  w[6:0] = 7'b0100011;
            K_RTYPE:  w[6:0] = 7'b0110011;
            K_BRANCH: w[6:0] = 7'b1100011;
            default:  w[6:0] = 7'b1111111;
        endcase
        w[30] = bit30;
        return w;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic addCycle(input logic [2:0] st, input logic mr, input logic z,
                            input logic [31:0] ins, input logic [13:0] outs,
                            input logic retire, input logic trapAfter);
        cycle_t c;
        c.st = st; c.mr = mr; c.z = z; c.ins = ins; c.outs = outs;
        c.retire = retire; c.trapAfter = trapAfter;
        plan.push_back(c);
    endtask

    // Expected timeline of one instruction from the first fetch cycle on.
    task automatic expandInstr(input int kind, input int fetchWait, input int memWait,
                               input logic zeroVal, input logic tieReady,
                               input logic [31:0] word);
        logic isStore;
        isStore = (kind == K_STORE);
        for (int i = 0; i < fetchWait; i++)
            addCycle(3'd0, 1'b0, rbit(), lastInstr,
                     pk(1,0,0,0,0,0,0,0,4'h0,0,0), 1'b0, 1'b0);
        addCycle(3'd0, 1'b1, rbit(), lastInstr,
                 pk(1,0,0,1,1,0,0,0,4'h0,0,0), 1'b0, 1'b0);
        lastInstr = word;
        addCycle(3'd1, tieReady | rbit(), rbit(), word, 14'h0, 1'b0,
                 kind == K_ILLEGAL);
        if (kind == K_ILLEGAL) return;
        if (kind == K_BRANCH) begin
            addCycle(3'd2, tieReady | rbit(), zeroVal, word,
                     pk(0,0,0,0,zeroVal,zeroVal,0,1,4'h1,0,1), 1'b1, 1'b0);
            return;
        end
        if (kind == K_RTYPE) begin
            addCycle(3'd2, tieReady | rbit(), rbit(), word,
                     pk(0,0,0,0,0,0,0,1,{3'b000, word[30]},0,0), 1'b0, 1'b0);
            addCycle(3'd4, tieReady | rbit(), rbit(), word,
                     pk(0,0,0,0,0,0,1,0,4'h0,0,0), 1'b1, 1'b0);
            return;
        end
        addCycle(3'd2, tieReady | rbit(), rbit(), word,
                 pk(0,0,0,0,0,0,0,0,4'h0,0,0), 1'b0, 1'b0);
        for (int i = 0; i < memWait; i++)
            addCycle(3'd3, 1'b0, rbit(), word,
                     pk(1,1,isStore,0,0,0,0,0,4'h0,0,0), 1'b0, 1'b0);
        addCycle(3'd3, 1'b1, rbit(), word,
                 pk(1,1,isStore,0,0,0,0,0,4'h0,0,0), isStore, 1'b0);
        if (!isStore)
            addCycle(3'd4, tieReady | rbit(), rbit(), word,
                     pk(0,0,0,0,0,0,1,0,4'h0,1,0), 1'b1, 1'b0);
    endtask

    task automatic applyStimulus(input logic mr, input logic z, input logic [31:0] ins);
        memReady = mr;
        zero     = z;
        instr    = ins;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t",
                   tag, observed, expected, $time);
        end
    endtask

    // Replay up to maxCycles planned cycles; entered and left at a falling edge.
    task automatic runPlan(input int maxCycles);
        cycle_t c;
        int n;
        n = 0;
        while (plan.size() > 0 && n < maxCycles) begin
            c = plan.pop_front();
            applyStimulus(c.mr, c.z, c.ins);
            #1;
            checkOutput("state",   32'(state),      32'(c.st));
            checkOutput("strobes", 32'(obsOuts),    32'(c.outs));
            checkOutput("instret", 32'(instret),    32'(expInstret));
            checkOutput("illegal", 32'(illegal),    32'(expIllegal));
            if (c.retire) expInstret = (expInstret + 1) % (1 << RW);
            if (c.trapAfter) expIllegal = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, rbit(), lastInstr);
        #1;
        checkOutput("resetStrobes", 32'(obsOuts), 32'h0);
        @(negedge clk);
        checkOutput("resetState",   32'(state),   32'h0);
        checkOutput("resetInstret", 32'(instret), 32'h0);
        checkOutput("resetIllegal", 32'(illegal), 32'h0);
        reset = 1'b0;
        expInstret = 0;
        expIllegal = 1'b0;
        plan.delete();
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        doReset();

        expandInstr(K_LOAD, 0, 0, 1'b0, 1'b1, mkWord(K_LOAD, rbit()));
        runPlan(1000);
        expandInstr(K_STORE, 0, 3, 1'b0, 1'b0, mkWord(K_STORE, rbit()));
        runPlan(1000);
        expandInstr(K_RTYPE, 0, 0, 1'b0, 1'b0, mkWord(K_RTYPE, 1'b1));
        runPlan(1000);
        expandInstr(K_BRANCH, 0, 0, 1'b1, 1'b0, mkWord(K_BRANCH, rbit()));
        runPlan(1000);
        expandInstr(K_BRANCH, 0, 0, 1'b0, 1'b0, mkWord(K_BRANCH, rbit()));
        runPlan(1000);

        expandInstr(K_ILLEGAL, 1, 0, 1'b0, 1'b0, mkWord(K_ILLEGAL, rbit()));
        for (int i = 0; i < 10; i++)
            addCycle(3'd5, rbit(), rbit(), lastInstr, 14'h0, 1'b0, 1'b0);
        runPlan(1000);
        doReset();

        expandInstr(K_RTYPE, 1, 0, 1'b0, 1'b0, mkWord(K_RTYPE, 1'b0));
        runPlan(1000);
        expandInstr(K_LOAD, 0, 5, 1'b0, 1'b0, mkWord(K_LOAD, rbit()));
        runPlan(4);
        doReset();

        for (int i = 0; i < 20; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            expandInstr(kind, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                        rbit(), 1'b0, mkWord(kind, rbit()));
            runPlan(1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
